// File: rtl/timer_counter.sv
// Programmable system timer: prescaled up/down counter with limit/reload wrap,
// one-shot expiry and a sticky interrupt flag.
module timer_counter #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned PRE_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 dir,
  input  logic                 oneshot,
  input  logic [PRE_WIDTH-1:0] prescale,
  input  logic                 load,
  input  logic [WIDTH-1:0]     load_value,
  input  logic [WIDTH-1:0]     limit,
  input  logic [WIDTH-1:0]     reload_value,
  input  logic                 irq_clear,
  output logic [WIDTH-1:0]     count,
  output logic                 tick,
  output logic                 terminal,
  output logic                 running,
  output logic                 irq
);

  typedef enum logic {
    ARMED = 1'b0,
    DONE  = 1'b1
  } state_t;

  state_t               state;
  logic [PRE_WIDTH-1:0] pre_cnt;
  logic                 active;
  logic                 step;
  logic                 hit;

  // >= rather than == so a mid-run drop of prescale below pre_cnt steps at once
  assign active  = enable && (state == ARMED);
  assign step    = active && (pre_cnt >= prescale);
  assign hit     = step && (count == limit);
  assign running = active;

  always_ff @(posedge clk) begin
    if (reset) begin
      count    <= '0;
      pre_cnt  <= '0;
      tick     <= 1'b0;
      terminal <= 1'b0;
      irq      <= 1'b0;
      state    <= ARMED;
    end else begin
      tick     <= 1'b0;
      terminal <= 1'b0;
      if (irq_clear) begin
        irq <= 1'b0;
      end
      if (load) begin
        count   <= load_value;
        pre_cnt <= '0;
        state   <= ARMED;
      end else if (step) begin
        pre_cnt <= '0;
        tick    <= 1'b1;
        if (hit) begin
          // terminal set takes precedence over a coincident irq_clear
          count    <= reload_value;
          terminal <= 1'b1;
          irq      <= 1'b1;
          if (oneshot) begin
            state <= DONE;
          end
        end else if (dir) begin
          count <= count - WIDTH'(1);
        end else begin
          count <= count + WIDTH'(1);
        end
      end else if (active) begin
        pre_cnt <= pre_cnt + PRE_WIDTH'(1);
      end
    end
  end

endmodule

// File: doc/timer_counter.md
Name: timer_counter

Overview:
Parametrised programmable timer/counter. Generalises the plain enable-gated up counter with:
- configurable width
- a prescaler
- up/down direction
- synchronous load
- limit/reload wrap
- one-shot mode
- a sticky interrupt flag

Sits on the CPU peripheral bus as the system timer. Software sets the load, limit and reload registers; the timer raises `irq` on terminal events.

Parameters:
WIDTH, 32, counter width in bits
PRE_WIDTH, 8, prescaler width in bits

Ports:
clk  in  1  clock, all logic on posedge
reset  in  1  synchronous, active-high reset
enable  in  1  count gate; prescaler and counter hold while low
dir  in  1  0 = count up, 1 = count down
oneshot  in  1  1 = stop after first terminal event
prescale  in  PRE_WIDTH  counter steps once every prescale+1 enabled cycles
load  in  1  synchronous load strobe
load_value  in  WIDTH  value written to count on load
limit  in  WIDTH  terminal value
reload_value  in  WIDTH  value count takes after a terminal event
irq_clear  in  1  clears irq
count  out  WIDTH  current count
tick  out  1  one-cycle pulse, count stepped this cycle
terminal  out  1  one-cycle pulse, terminal event took effect
running  out  1  state==ARMED and enable
irq  out  1  sticky terminal flag

Behaviour:
- Reset values (applied on a posedge where reset=1):
  - count=0, pre_cnt=0, tick=0, terminal=0, irq=0
  - state=ARMED
- Reset overrides every other input.
- States:
  - ARMED: counting permitted.
  - DONE: one-shot expired; count frozen.
  - ARMED -> DONE on a terminal event while oneshot=1.
  - DONE -> ARMED only on load.
- Internal step condition: `step = enable & (state==ARMED) & (pre_cnt >= prescale)`.
  - Use `>=` so that lowering `prescale` mid-run never stalls the counter.
- Prescaler:
  - While enable & ARMED: pre_cnt <= step ? 0 : pre_cnt+1.
  - Otherwise pre_cnt holds.
  - prescale=0 gives a step on every enabled cycle.
- Terminal condition: `step & (count==limit)`. This applies in both directions.
- Next count on step:
  - Terminal: count <= reload_value.
  - Non-terminal, dir=0: count <= count+1.
  - Non-terminal, dir=1: count <= count-1.
  - Arithmetic is modulo 2^WIDTH: up wraps all-ones -> 0; down wraps 0 -> all-ones. Natural wrap does not raise terminal.
- Load:
  - count <= load_value, pre_cnt <= 0, state <= ARMED.
  - No tick, no terminal, irq unaffected.
  - Priority is reset > load > step; load in the same cycle as a step discards the step.
- Output timing:
  - tick and terminal are registered, high for exactly the one cycle in which the new count value is visible.
  - Latency is one clock from the step edge.
- irq:
  - Set on terminal event; cleared by irq_clear.
  - Simultaneous terminal and irq_clear: set wins, irq=1.
- oneshot:
  - Sampled at the terminal event.
  - After the terminal event count shows reload_value and is frozen in DONE.
  - Changing oneshot while in DONE has no effect until load.
- Dynamic inputs:
  - dir and limit are sampled live each step.
  - If limit is never equal to count, the counter free-runs with natural wrap.
- running is combinational from state and enable.

Test Plan:
- Reset, then enable=1, prescale=0, dir=0, limit=all-ones, reload=0, 5 cycles -> count=5, tick high on each of the 5 cycles, terminal=0, irq=0.
- load_value=0, prescale=3, enable=1 for 12 cycles -> count=3, tick every 4th cycle; drop enable for 5 cycles -> count and pre_cnt hold, running=0.
- dir=1, load_value=2, limit=0, reload=9, prescale=0 -> sequence 2,1,0,9,8; terminal and irq set in the cycle count=9; assert irq_clear -> irq=0 next cycle.
- oneshot=1, dir=0, load_value=0, limit=3, reload=7 -> 0,1,2,3,7 then frozen in DONE, running=0; pulse load with load_value=0 -> ARMED, counting resumes.
- Wrap and priority cases:
  - dir=0, load_value=all-ones, limit=5 -> next count=0 with no terminal.
  - load asserted in the same cycle as a terminal step -> count=load_value, no terminal.
  - irq_clear coincident with a terminal event -> irq=1.
- Reset asserted mid-count with load=1 -> count=0, pre_cnt=0, state=ARMED, irq=0 next cycle.
